// File: rtl/alu_arbiter_if.sv
// Request/issue/response bundle between requesters A/B, the arbiter and the execute ALU.
// With ALU_ARB_LOCK_EN defined the bundle also carries a_lock/b_lock.
interface alu_arbiter_if #(parameter int DATA_W = 16);
  // Handshake: an operation transfers on a rising edge where x_valid & x_ready;
  // x_ready never depends on x_ready of the other side and operands stay stable until then.
  logic              a_valid, a_ready;
  logic [3:0]        a_op;
  logic [2:0]        a_dest;
  logic [DATA_W-1:0] a_value1, a_value2, a_stvalue;
  logic              b_valid, b_ready;
  logic [3:0]        b_op;
  logic [2:0]        b_dest;
  logic [DATA_W-1:0] b_value1, b_value2, b_stvalue;
  logic              stall;
  logic [55:0]       idbus;
  logic [39:0]       exbus;
  logic              rsp_a_valid, rsp_b_valid;
  logic [DATA_W-1:0] rsp_result;
  logic [2:0]        rsp_dest;
`ifdef ALU_ARB_LOCK_EN
  logic              a_lock, b_lock;

  modport slave (
    input  a_valid, a_op, a_dest, a_value1, a_value2, a_stvalue, a_lock,
    input  b_valid, b_op, b_dest, b_value1, b_value2, b_stvalue, b_lock,
    input  stall, exbus,
    output a_ready, b_ready, idbus, rsp_a_valid, rsp_b_valid, rsp_result, rsp_dest
  );
  modport master (
    output a_valid, a_op, a_dest, a_value1, a_value2, a_stvalue, a_lock,
    output b_valid, b_op, b_dest, b_value1, b_value2, b_stvalue, b_lock,
    output stall, exbus,
    input  a_ready, b_ready, idbus, rsp_a_valid, rsp_b_valid, rsp_result, rsp_dest
  );
`else
  modport slave (
    input  a_valid, a_op, a_dest, a_value1, a_value2, a_stvalue,
    input  b_valid, b_op, b_dest, b_value1, b_value2, b_stvalue,
    input  stall, exbus,
    output a_ready, b_ready, idbus, rsp_a_valid, rsp_b_valid, rsp_result, rsp_dest
  );
  modport master (
    output a_valid, a_op, a_dest, a_value1, a_value2, a_stvalue,
    output b_valid, b_op, b_dest, b_value1, b_value2, b_stvalue,
    output stall, exbus,
    input  a_ready, b_ready, idbus, rsp_a_valid, rsp_b_valid, rsp_result, rsp_dest
  );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of the execute ALU between requesters A and B, with owner tags
// to steer exbus results back. ALU_ARB_LOCK_EN adds a_lock/b_lock grant holding.
module alu_arbiter #(
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 2
) (
  input logic         clock,
  input logic         resetn,
  alu_arbiter_if.slave bus
);

  logic                 grant_a, grant_b, accept, lock_hold;
  logic                 last_grant_b;   // 1: B was granted last, 0: A
  logic [55:0]          idbus_q;
  logic [TAG_DEPTH-1:0] tag_valid, tag_owner_b;
  logic                 unused_exbus;

  always_comb begin
    lock_hold = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    lock_hold = last_grant_b ? (bus.b_lock & bus.b_valid) : (bus.a_lock & bus.a_valid);
`else
    lock_hold = 1'b0;
`endif
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!bus.stall) begin
      if (bus.a_valid && !bus.b_valid) begin
        grant_a = 1'b1;
      end else if (bus.b_valid && !bus.a_valid) begin
        grant_b = 1'b1;
      end else if (bus.a_valid && bus.b_valid) begin
        // A held lock keeps the previous owner, otherwise the other side wins the tie
        grant_a = lock_hold ? !last_grant_b : last_grant_b;
        grant_b = !grant_a;
      end
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;
  assign accept      = grant_a | grant_b;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idbus_q      <= '0;
      last_grant_b <= 1'b1;
    end else if (grant_a) begin
      idbus_q      <= {1'b1, bus.a_op, bus.a_dest, bus.a_value1, bus.a_value2, bus.a_stvalue};
      last_grant_b <= 1'b0;
    end else if (grant_b) begin
      idbus_q      <= {1'b1, bus.b_op, bus.b_dest, bus.b_value1, bus.b_value2, bus.b_stvalue};
      last_grant_b <= 1'b1;
    end else begin
      // Bubble: drop valid only, payload fields keep their last values
      idbus_q[55]  <= 1'b0;
    end
  end

  assign bus.idbus = idbus_q;

  // Owner tags advance every cycle so the last stage lines up with the ALU's exbus register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tag_valid   <= '0;
      tag_owner_b <= '0;
    end else begin
      tag_valid[0]   <= accept;
      tag_owner_b[0] <= grant_b;
      for (int i = 1; i < TAG_DEPTH; i++) begin
        tag_valid[i]   <= tag_valid[i-1];
        tag_owner_b[i] <= tag_owner_b[i-1];
      end
    end
  end

  assign bus.rsp_a_valid = bus.exbus[39] & tag_valid[TAG_DEPTH-1] & !tag_owner_b[TAG_DEPTH-1];
  assign bus.rsp_b_valid = bus.exbus[39] & tag_valid[TAG_DEPTH-1] &  tag_owner_b[TAG_DEPTH-1];
  assign bus.rsp_result  = bus.exbus[31:16];
  assign bus.rsp_dest    = bus.exbus[34:32];

  assign unused_exbus = ^{bus.exbus[38:35], bus.exbus[15:0]};

endmodule
